// File: rtl/c66x_power_supervisor.sv
// c66x_power_supervisor
// Drives the enable input of the C66x power sequencer. After reset it waits
// through a power-on delay, then follows the host run request. It watches the
// sequencer state code for a startup timeout or an unexpected shutdown, retries
// a bounded number of times, and latches a fault until the host clears it.
// All outputs are registered and are computed from the next-state value.
module c66x_power_supervisor #(
    parameter int TICK_DIV              = 500,
    parameter int POR_DELAY_TICKS       = 100,
    parameter int STARTUP_TIMEOUT_TICKS = 2000,
    parameter int COOLDOWN_TICKS        = 500,
    parameter int MAX_RETRIES           = 3
) (
    input  logic       sysclk,
    input  logic       reset_INV,
    input  logic       run_req,
    input  logic       fault_clear,
    input  logic [3:0] seq_state,
    output logic       enable,
    output logic       power_good,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [2:0] sup_state
);

    // Supervisor state codes
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_ON    = 3'd3;
    localparam logic [2:0] ST_COOL  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    // Sequencer state codes of interest
    localparam logic [3:0] SEQ_OFF       = 4'd0;
    localparam logic [3:0] SEQ_ON        = 4'd9;
    localparam logic [3:0] SEQ_SHUT_BASE = 4'd10;

    localparam int         PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [11:0] POR_T    = 12'(POR_DELAY_TICKS);
    localparam logic [11:0] TO_T     = 12'(STARTUP_TIMEOUT_TICKS);
    localparam logic [11:0] CD_T     = 12'(COOLDOWN_TICKS);
    localparam logic [11:0] TMR_MAX  = 12'hFFF;
    localparam logic [1:0]  MAX_R    = 2'(MAX_RETRIES);

    // Synchroniser and filter registers
    logic          run_q1, run_q2;
    logic          clr_q1, clr_q2;
    logic [3:0]    seq_q1, seq_q2, seq_filt_q, seq_filt_d;

    // Timebase registers
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_s;
    logic [11:0]   timer_q, timer_d;

    // FSM registers
    logic [2:0]    state_q, state_d;
    logic [1:0]    retry_q, retry_d;
    logic          fault_q, fault_d;
    logic          seen_q, seen_d;
    logic          enable_q, enable_d;
    logic          pg_q, pg_d;

    // Helper signals for the failure path
    logic [1:0]    retry_inc_s;
    logic          run_fail_s;

    // 2-FF synchronisers for host levels and the two-stage sequencer capture
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            run_q1     <= 1'b0;
            run_q2     <= 1'b0;
            clr_q1     <= 1'b0;
            clr_q2     <= 1'b0;
            seq_q1     <= 4'd0;
            seq_q2     <= 4'd0;
            seq_filt_q <= 4'd0;
        end else begin
            run_q1     <= run_req;
            run_q2     <= run_q1;
            clr_q1     <= fault_clear;
            clr_q2     <= clr_q1;
            seq_q1     <= seq_state;
            seq_q2     <= seq_q1;
            seq_filt_q <= seq_filt_d;
        end
    end

    // Filtered sequencer code only follows when both capture stages agree
    always_comb begin
        if (seq_q1 == seq_q2) begin
            seq_filt_d = seq_q2;
        end else begin
            seq_filt_d = seq_filt_q;
        end
    end

    // Prescaler next value and one-cycle tick at the last count
    always_comb begin
        tick_s = (presc_q == TICK_LAST);
        if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // State timer: cleared on any state change, saturating tick counter otherwise
    always_comb begin
        if (state_d != state_q) begin
            timer_d = 12'd0;
        end else if (tick_s && (timer_q != TMR_MAX)) begin
            timer_d = timer_q + 12'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Tracks whether the sequencer left "off" since this RUN attempt began
    always_comb begin
        if (state_q != ST_RUN) begin
            seen_d = 1'b0;
        end else if (seq_filt_q != SEQ_OFF) begin
            seen_d = 1'b1;
        end else begin
            seen_d = seen_q;
        end
    end

    // Failure conditions while waiting for the sequencer to come up
    always_comb begin
        retry_inc_s = (retry_q == 2'd3) ? 2'd3 : (retry_q + 2'd1);
        run_fail_s  = (seq_filt_q >= SEQ_SHUT_BASE) ||
                      ((seq_filt_q == SEQ_OFF) && seen_q) ||
                      (timer_q >= TO_T);
    end

    // Supervisor next-state, retry and fault logic
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fault_d = fault_q;
        case (state_q)
            ST_INIT: begin
                if (timer_q >= POR_T) begin
                    state_d = ST_COOL;
                end else begin
                    state_d = state_q;
                end
            end
            ST_IDLE: begin
                if (run_q2 && !fault_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (seq_filt_q == SEQ_ON) begin
                    state_d = ST_ON;
                    retry_d = 2'd0;
                end else if (run_fail_s) begin
                    retry_d = retry_inc_s;
                    if (retry_inc_s == MAX_R) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_COOL;
                    end
                end else if (!run_q2) begin
                    state_d = ST_COOL;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ON: begin
                if (seq_filt_q != SEQ_ON) begin
                    retry_d = retry_inc_s;
                    if (retry_inc_s == MAX_R) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_COOL;
                    end
                end else if (!run_q2) begin
                    state_d = ST_COOL;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COOL: begin
                if ((timer_q >= CD_T) && (seq_filt_q == SEQ_OFF)) begin
                    if (run_q2 && !fault_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_FAULT: begin
                fault_d = 1'b1;
                if (clr_q2 && !run_q2) begin
                    state_d = ST_COOL;
                    fault_d = 1'b0;
                    retry_d = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                // Unused codes recover through COOLDOWN so the sequencer is seen off
                state_d = ST_COOL;
            end
        endcase
    end

    // Output decode from the next state so outputs change with the state register
    always_comb begin
        enable_d = (state_d == ST_RUN) || (state_d == ST_ON);
        pg_d     = (state_d == ST_ON) && (seq_filt_q == SEQ_ON);
    end

    // Timebase and FSM state registers
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            presc_q  <= {PW{1'b0}};
            timer_q  <= 12'd0;
            state_q  <= ST_INIT;
            retry_q  <= 2'd0;
            fault_q  <= 1'b0;
            seen_q   <= 1'b0;
            enable_q <= 1'b0;
            pg_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            timer_q  <= timer_d;
            state_q  <= state_d;
            retry_q  <= retry_d;
            fault_q  <= fault_d;
            seen_q   <= seen_d;
            enable_q <= enable_d;
            pg_q     <= pg_d;
        end
    end

    assign enable      = enable_q;
    assign power_good  = pg_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign sup_state   = state_q;

endmodule

// File: tb/tb_c66x_power_supervisor.sv
// Directed bench for c66x_power_supervisor with short timing parameters.
// Inputs are driven and outputs sampled 1ns after each rising sysclk edge.
module tb_c66x_power_supervisor;

    logic       sysclk;
    logic       reset_INV;
    logic       run_req;
    logic       fault_clear;
    logic [3:0] seq_state;
    logic       enable;
    logic       power_good;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] sup_state;

    int n_checks;
    int n_errors;

    c66x_power_supervisor #(
        .TICK_DIV              (4),
        .POR_DELAY_TICKS       (10),
        .STARTUP_TIMEOUT_TICKS (20),
        .COOLDOWN_TICKS        (5),
        .MAX_RETRIES           (3)
    ) dut (
        .sysclk      (sysclk),
        .reset_INV   (reset_INV),
        .run_req     (run_req),
        .fault_clear (fault_clear),
        .seq_state   (seq_state),
        .enable      (enable),
        .power_good  (power_good),
        .fault       (fault),
        .retry_count (retry_count),
        .sup_state   (sup_state)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Hard stop in case something blocks unexpectedly
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int en_high;
        int pg_drops;
        n_checks    = 0;
        n_errors    = 0;
        reset_INV   = 1'b0;
        run_req     = 1'b1;
        fault_clear = 1'b0;
        seq_state   = 4'd0;

        // Reset state
        repeat (3) step();
        check_eq("rst_enable", enable, 0);
        check_eq("rst_pg", power_good, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_retry", retry_count, 0);
        check_eq("rst_state", sup_state, 0);

        // 1: power-on hold 40 cycles, cooldown 20 cycles, enable at edge 61
        @(negedge sysclk);
        reset_INV = 1'b1;
        en_high = 0;
        for (int e = 1; e <= 61; e++) begin
            step();
            if (e < 61 && enable === 1'b1) en_high++;
            if (e == 40) check_eq("s1_init_e40", sup_state, 0);
            if (e == 41) check_eq("s1_cool_e41", sup_state, 4);
            if (e == 60) check_eq("s1_cool_e60", sup_state, 4);
            if (e == 61) begin
                check_eq("s1_run_e61", sup_state, 2);
                check_eq("s1_enable_e61", enable, 1);
            end
        end
        check_eq("s1_enable_low_60", en_high, 0);

        // 2: startup ramp 1..8, then 9 gives ON four edges later
        for (int v = 1; v <= 8; v++) begin
            seq_state = 4'(v);
            repeat (3) step();
        end
        check_eq("s2_still_run", sup_state, 2);
        seq_state = 4'd9;
        repeat (3) step();
        check_eq("s2_pg_early", power_good, 0);
        step();
        check_eq("s2_pg", power_good, 1);
        check_eq("s2_state_on", sup_state, 3);
        check_eq("s2_retry", retry_count, 0);

        // 3: trip in ON
        seq_state = 4'd10;
        repeat (3) step();
        check_eq("s3_enable_before", enable, 1);
        step();
        check_eq("s3_enable_off", enable, 0);
        check_eq("s3_retry", retry_count, 1);
        check_eq("s3_state_cool", sup_state, 4);
        check_eq("s3_pg_off", power_good, 0);
        seq_state = 4'd0;
        n = 0;
        while (enable !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check_eq("s3_reenable_seen", (n < 200) ? 1 : 0, 1);
        check_eq("s3_cooldown_min", (n >= 17) ? 1 : 0, 1);
        check_eq("s3_rerun_state", sup_state, 2);
        check_eq("s3_retry_kept", retry_count, 1);

        // 4: two startup timeouts with sequencer stuck at 3
        for (int a = 0; a < 2; a++) begin
            if (a > 0) begin
                seq_state = 4'd0;
                n = 0;
                while (enable !== 1'b1 && n < 200) begin
                    step();
                    n++;
                end
                check_eq("s4_rerun_seen", (n < 200) ? 1 : 0, 1);
            end
            seq_state = 4'd3;
            n = 0;
            while (enable === 1'b1 && n < 200) begin
                step();
                n++;
            end
            check_eq("s4_timeout_len", (n >= 78 && n <= 81) ? 1 : 0, 1);
            if (a == 0) begin
                check_eq("s4_retry2", retry_count, 2);
                check_eq("s4_cool", sup_state, 4);
                check_eq("s4_nofault", fault, 0);
            end else begin
                check_eq("s4_fault", fault, 1);
                check_eq("s4_fault_state", sup_state, 5);
                check_eq("s4_fault_enable", enable, 0);
                check_eq("s4_retry3", retry_count, 3);
            end
        end

        // 5: clear ignored while run_req high, honoured once it drops
        fault_clear = 1'b1;
        repeat (10) step();
        check_eq("s5_clear_ignored", fault, 1);
        check_eq("s5_state_fault", sup_state, 5);
        run_req = 1'b0;
        repeat (2) step();
        check_eq("s5_state_hold", sup_state, 5);
        step();
        check_eq("s5_state_cool", sup_state, 4);
        check_eq("s5_fault_cleared", fault, 0);
        check_eq("s5_retry_cleared", retry_count, 0);
        seq_state   = 4'd0;
        fault_clear = 1'b0;
        n = 0;
        while (sup_state !== 3'd1 && n < 100) begin
            step();
            n++;
        end
        check_eq("s5_idle", sup_state, 1);
        check_eq("s5_idle_enable", enable, 0);

        // run_req to enable latency from IDLE is three edges
        run_req = 1'b1;
        repeat (2) step();
        check_eq("lat_enable_e2", enable, 0);
        step();
        check_eq("lat_enable_e3", enable, 1);
        check_eq("lat_state_run", sup_state, 2);

        // 6: one-cycle glitch in ON is filtered
        seq_state = 4'd9;
        n = 0;
        while (power_good !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_eq("s6_pg_up", power_good, 1);
        seq_state = 4'd12;
        step();
        seq_state = 4'd9;
        pg_drops = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (power_good !== 1'b1) pg_drops++;
        end
        check_eq("s6_glitch_drops", pg_drops, 0);
        check_eq("s6_glitch_state", sup_state, 3);
        check_eq("s6_glitch_retry", retry_count, 0);

        // Host drop from ON is not a failure
        run_req = 1'b0;
        n = 0;
        while (sup_state !== 3'd4 && n < 10) begin
            step();
            n++;
        end
        check_eq("s6_drop_cool", sup_state, 4);
        check_eq("s6_drop_retry", retry_count, 0);

        // Async reset mid-RUN
        seq_state = 4'd0;
        run_req   = 1'b1;
        n = 0;
        while (enable !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_eq("s6_run_again", enable, 1);
        #3;
        reset_INV = 1'b0;
        #1;
        check_eq("s6_async_enable", enable, 0);
        check_eq("s6_async_state", sup_state, 0);
        repeat (2) step();
        @(negedge sysclk);
        reset_INV = 1'b1;
        repeat (5) step();
        check_eq("s6_back_init", sup_state, 0);
        check_eq("s6_init_enable", enable, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
